// File: rtl/run_event_monitor.sv
// run_event_monitor
//   Sits downstream of the serial run detector. It watches the detector's input
//   bit w and its flag z, which is high while at least five equal consecutive bits
//   persist. From these it counts detected runs, records the bit value of each run,
//   measures the current run length and the longest completed run, and raises a
//   sticky interrupt. All outputs come straight from flops.
//
// Ports
//   clk        in   1      single clock, all logic on posedge
//   rst_n      in   1      synchronous active-low reset
//   w          in   1      serial bit stream that also feeds the detector
//   z          in   1      detector flag
//   clr        in   1      clears evt_count, max_run and irq (one-cycle pulse)
//   thresh     in   CNT_W  event count that raises irq; 0 disables this source
//   evt_count  out  CNT_W  number of z rising edges, saturating
//   evt_pol    out  1      bit value of the most recent run
//   run_len    out  LEN_W  cycles z has been high in the current run, 0 when idle
//   max_run    out  LEN_W  longest completed run since reset or clr
//   long_run   out  1      high while the current run is at least LONG_LIM long
//   irq        out  1      sticky interrupt
module run_event_monitor #(
  parameter int CNT_W    = 8,
  parameter int LEN_W    = 8,
  parameter int LONG_LIM = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w,
  input  logic             z,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_pol,
  output logic [LEN_W-1:0] run_len,
  output logic [LEN_W-1:0] max_run,
  output logic             long_run,
  output logic             irq
);

  localparam logic [LEN_W-1:0] LONG_LIM_V = LEN_W'(LONG_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LONG = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             w_d_q;
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic             evt_pol_q, evt_pol_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [LEN_W-1:0] max_run_q, max_run_d;
  logic             long_run_q, long_run_d;
  logic             irq_q, irq_d;

  logic             evt_hit;
  logic             enter_long;
  logic             run_end;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    evt_count_d = evt_count_q;
    evt_pol_d   = evt_pol_q;
    run_len_d   = run_len_q;
    max_run_d   = max_run_q;
    irq_d       = irq_q;
    evt_hit     = 1'b0;
    enter_long  = 1'b0;
    run_end     = 1'b0;
    cnt_next    = sat_inc_cnt(evt_count_q);

    case (state_q)
      IDLE: begin
        if (z) begin
          evt_hit   = 1'b1;
          // w_d_q still holds w from the cycle before z rose: the run's bit
          evt_pol_d = w_d_q;
          run_len_d = LEN_W'(1);
          if (LONG_LIM_V == LEN_W'(1)) begin
            state_d    = LONG;
            enter_long = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (z) begin
          run_len_d = sat_inc_len(run_len_q);
          if (run_len_d >= LONG_LIM_V) begin
            state_d    = LONG;
            enter_long = 1'b1;
          end
        end else begin
          run_end = 1'b1;
        end
      end
      LONG: begin
        if (z) run_len_d = sat_inc_len(run_len_q);
        else   run_end   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (run_end) begin
      state_d   = IDLE;
      run_len_d = '0;
      if (run_len_q > max_run_q) max_run_d = run_len_q;
    end

    if (evt_hit) begin
      evt_count_d = cnt_next;
      // a count held at saturation is not a new match
      if ((thresh != '0) && (cnt_next == thresh) && (cnt_next != evt_count_q))
        irq_d = 1'b1;
    end
    if (enter_long) irq_d = 1'b1;

    // clr overrides any same-edge increment, max update or irq set
    if (clr) begin
      evt_count_d = '0;
      max_run_d   = '0;
      irq_d       = 1'b0;
    end

    long_run_d = (state_d == LONG);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_d_q       <= 1'b0;
      evt_count_q <= '0;
      evt_pol_q   <= 1'b0;
      run_len_q   <= '0;
      max_run_q   <= '0;
      long_run_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_d_q       <= w;
      evt_count_q <= evt_count_d;
      evt_pol_q   <= evt_pol_d;
      run_len_q   <= run_len_d;
      max_run_q   <= max_run_d;
      long_run_q  <= long_run_d;
      irq_q       <= irq_d;
    end
  end

  assign evt_count = evt_count_q;
  assign evt_pol   = evt_pol_q;
  assign run_len   = run_len_q;
  assign max_run   = max_run_q;
  assign long_run  = long_run_q;
  assign irq       = irq_q;

endmodule
